// File: rtl/vga_disp_pkg.sv
// Shared constants and types for the on-screen channel value display path.
package vga_disp_pkg;

   localparam int CHANNELS = 13;
   localparam int DATA_W   = 12;
   localparam int IDX_W    = 4;
   localparam int OVR_W    = 8;

   localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(CHANNELS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COMMIT = 2'd1,
      DONE   = 2'd2
   } commit_state_t;

   function automatic logic ch_valid(input logic [IDX_W-1:0] ch);
      return (ch <= LAST_CH);
   endfunction

endpackage

// File: rtl/channel_shadow_bank.sv
// Shadow copy of every channel value plus its pending flag; written by the
// measurement side, read and cleared one channel at a time during commit.
module channel_shadow_bank
   import vga_disp_pkg::*;
(
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_ch,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_pend,
   input  logic [IDX_W-1:0]  cm_idx,
   input  logic              cm_clear,
   output logic [DATA_W-1:0] cm_data,
   output logic              cm_pend
);

   logic [DATA_W-1:0]   shadow [CHANNELS];
   logic [CHANNELS-1:0] pend;

   // Writes and clears never target the same cycle: writes only happen while idle.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < CHANNELS; k++) shadow[k] <= '0;
         pend <= '0;
      end else begin
         if (we && ch_valid(wr_ch)) begin
            shadow[wr_ch] <= wr_data;
            pend[wr_ch]   <= 1'b1;
         end
         if (cm_clear && ch_valid(cm_idx)) pend[cm_idx] <= 1'b0;
      end
   end

   assign wr_pend = ch_valid(wr_ch)  ? pend[wr_ch]    : 1'b0;
   assign cm_pend = ch_valid(cm_idx) ? pend[cm_idx]   : 1'b0;
   assign cm_data = ch_valid(cm_idx) ? shadow[cm_idx] : '0;

endmodule

// File: rtl/frame_commit_scheduler.sv
// Collects channel value writes during active video and commits pending values
// to the display registers during vertical blanking, one channel per cycle.
module frame_commit_scheduler
   import vga_disp_pkg::*;
(
   input  logic                         pclk,
   input  logic                         rst_n,
   input  logic                         vblnk_in,
   input  logic                         wr_valid,
   input  logic [IDX_W-1:0]             wr_ch,
   input  logic [DATA_W-1:0]            wr_data,
   output logic                         wr_ready,
   output logic [CHANNELS*DATA_W-1:0]   disp_data,
   output logic                         commit_done,
   output logic                         commit_abort,
   output logic                         bad_ch,
   output logic [OVR_W-1:0]             overrun_cnt
);

   commit_state_t     state, state_d;
   logic [IDX_W-1:0]  idx, idx_d;
   logic              vblnk_q;
   logic              vblnk_rise;
   logic              accept, we;
   logic              wr_pend, cm_pend, cm_clear;
   logic              done_d, abort_d;
   logic [DATA_W-1:0] cm_data;

   assign vblnk_rise = vblnk_in && !vblnk_q;
   assign accept     = wr_valid && wr_ready;
   assign we         = accept && ch_valid(wr_ch);

   channel_shadow_bank u_bank (
      .pclk     (pclk),
      .rst_n    (rst_n),
      .we       (we),
      .wr_ch    (wr_ch),
      .wr_data  (wr_data),
      .wr_pend  (wr_pend),
      .cm_idx   (idx),
      .cm_clear (cm_clear),
      .cm_data  (cm_data),
      .cm_pend  (cm_pend)
   );

   always_comb begin
      state_d  = state;
      idx_d    = idx;
      cm_clear = 1'b0;
      done_d   = 1'b0;
      abort_d  = 1'b0;
      case (state)
         IDLE: begin
            if (vblnk_rise) begin
               state_d = COMMIT;
               idx_d   = '0;
            end
         end
         COMMIT: begin
            // Losing vblank mid-pass leaves the remaining channels pending for next frame.
            if (!vblnk_in) begin
               state_d = IDLE;
               idx_d   = '0;
               abort_d = 1'b1;
            end else begin
               cm_clear = cm_pend;
               if (idx == LAST_CH) begin
                  state_d = DONE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_d;
         idx   <= idx_d;
      end
   end

   // vblnk_q resets high so a reset released inside vblank does not start a pass.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vblnk_q      <= 1'b1;
         wr_ready     <= 1'b0;
         disp_data    <= '0;
         commit_done  <= 1'b0;
         commit_abort <= 1'b0;
         bad_ch       <= 1'b0;
         overrun_cnt  <= '0;
      end else begin
         vblnk_q      <= vblnk_in;
         wr_ready     <= (state_d == IDLE);
         commit_done  <= done_d;
         commit_abort <= abort_d;
         bad_ch       <= accept && !ch_valid(wr_ch);
         if (we && wr_pend && (overrun_cnt != {OVR_W{1'b1}}))
            overrun_cnt <= overrun_cnt + 1'b1;
         if (cm_clear)
            disp_data[idx*DATA_W +: DATA_W] <= cm_data;
      end
   end

endmodule

// File: doc/frame_commit_scheduler.md
# frame_commit_scheduler

Frame-synchronous update scheduler for the 13 on-screen channel voltage values. It accepts per-channel value writes from the measurement side through a valid/ready handshake and holds them in a shadow bank. It commits pending values to the display registers only during vertical blanking, one channel per cycle in fixed order, so the drawing pipeline never sees a value change mid-frame. It sits between the ADC/measurement logic and the draw stages that render channel values on top of the background.

## Interface
- CHANNELS, 13: number of display channels.
- DATA_W, 12: width of one channel value.
- IDX_W, 4: channel index width; must satisfy 2^IDX_W >= CHANNELS.
- pclk  in  1  pixel clock; single clock domain.
- rst_n  in  1  reset. Asynchronous, active-low.
- vblnk_in  in  1  vertical blanking from the timing chain.
- wr_valid  in  1  write request.
- wr_ch  in  IDX_W  target channel.
- wr_data  in  DATA_W  new value.
- wr_ready  out  1  write accepted when wr_valid && wr_ready at a pclk edge.
- disp_data  out  CHANNELS*DATA_W  committed values; channel k occupies bits [k*DATA_W +: DATA_W].
- commit_done  out  1  one-cycle pulse when a full commit pass completes.
- commit_abort  out  1  one-cycle pulse when a pass is cut short by the end of vblank.
- bad_ch  out  1  one-cycle pulse when an accepted write has wr_ch >= CHANNELS.
- overrun_cnt  out  8  saturating count of writes that overwrote a still-pending value.

## Operation
- State machine states: IDLE, COMMIT, DONE.
- IDLE:
  - wr_ready=1.
  - An accepted write with a valid channel stores wr_data into shadow[wr_ch] and sets pend[wr_ch].
  - If pend[wr_ch] was already 1, the latest value wins and overrun_cnt increments, saturating at 255.
  - An accepted write with an invalid channel is dropped and pulses bad_ch.
- Vblank edge detection: vblnk_q is a registered copy of vblnk_in. A rising edge (vblnk_in=1, vblnk_q=0) seen in IDLE moves the block to COMMIT with idx=0 and wr_ready=0.
- COMMIT, one step per cycle:
  - If vblnk_in=1: when pend[idx]=1, copy shadow[idx] into disp_data slot idx and clear pend[idx]. Then idx++.
  - When idx==CHANNELS-1 is processed, go to DONE.
  - If vblnk_in=0 at a step: do not commit, pulse commit_abort, return to IDLE. Channels not yet committed keep pend set and commit on the next frame.
- DONE: pulse commit_done, return to IDLE.
- wr_ready is 0 throughout COMMIT. This means no write can ever collide with a commit.
- Channels with pend=0 keep their current disp_data value.

## Timing
- Reset values: state=IDLE, vblnk_q=1, wr_ready=0, disp_data=0, shadow=0, pend=0, idx=0, commit_done=0, commit_abort=0, bad_ch=0, overrun_cnt=0.
- Because vblnk_q resets to 1, releasing reset while vblnk_in is already high does not start a commit. The first commit happens on the next vblank.
- wr_ready first goes to 1 on the first pclk edge after reset release.
- All outputs are registered. A write accepted at edge W is visible in shadow/pend after W, and bad_ch is high in the cycle after W.
- Commit sequence:
  - Let E0 be the edge that samples the vblank rising edge. wr_ready=0 after E0.
  - Channel k (0..12) is committed at edge E(k+1); its disp_data slot changes after that edge.
  - At E13 the state moves to DONE. commit_done is high in the cycle after E14; wr_ready=1 after E14.
  - Total: 14 cycles with wr_ready low per frame, well inside the vblank interval.
- Abort: if vblnk_in=0 is sampled at edge En (n=1..13), the state becomes IDLE at En. commit_abort and wr_ready=1 are visible after En.
- Reset mid-operation (any state): all state, pending data and outputs return to their reset values immediately (asynchronous). Pending values are lost.

## Structure
- Shared package vga_disp_pkg holds:
  - CHANNELS and DATA_W constants.
  - State typedef/encoding (IDLE, COMMIT, DONE).
  - Overrun counter width (8).
- One sub-module, channel_shadow_bank: the shadow registers plus pending bits. It has a write port (ch, data, we) and a commit port (idx, clear) returning data and pend.
- The FSM, vblank edge detect and output registers stay in frame_commit_scheduler.

## Test plan
- Reset release with vblnk_in=1, then vblnk falls and rises again -> no commit in the first vblank; commit runs on the next rising edge, all disp_data still 0 because nothing is pending.
- Write ch3=0x5A1 and ch12=0xFFF in active video, then vblank rises -> slot 3=0x5A1 after E4, slot 12=0xFFF after E13, commit_done pulse after E14, wr_ready low for exactly 14 cycles.
- Write ch0 three times (0x001, 0x002, 0x003) before vblank -> slot 0=0x003 after commit, overrun_cnt=2.
- Write wr_ch=13 with wr_data=0x123 -> bad_ch pulse one cycle after the handshake, no pend set, disp_data unchanged after the next commit.
- Pend all 13 channels, drop vblnk_in at E5 -> channels 0..3 committed, commit_abort pulse, no commit_done; channels 4..12 commit at the next vblank.
- Assert rst_n=0 at E6 of a commit pass -> outputs immediately at reset values, pend cleared; the next vblank commits nothing.
